// File: rtl/mac_tx_fcs_insert_pkg.sv
// -----------------------------------------------------------------------------
// mac_tx_fcs_insert_pkg
// Shared types and helpers for the 10G MAC TX FCS insertion stage:
//   - state_e          : FSM states of the insertion stage
//   - keep_to_count    : number of valid bytes in an LSB-contiguous keep
//   - count_to_keep    : LSB-contiguous keep mask for a byte count 0..8
//   - keep_to_mask     : keep expanded to a 64-bit byte mask
//   - crc32_update     : reflected CRC-32 (poly 0x04C11DB7) over n low bytes
// -----------------------------------------------------------------------------
package mac_tx_fcs_insert_pkg;

    localparam int          BYTE_W   = 8;
    localparam int          FCS_LEN  = 4;
    localparam int          DATA_W   = 64;
    localparam int          KEEP_W   = DATA_W / BYTE_W;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;   // reflected 0x04C11DB7

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_SPILL,
        ST_GAP,
        ST_DROP
    } state_e;

    function automatic logic [3:0] keep_to_count(input logic [KEEP_W-1:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + 4'(keep[i]);
        end
        return cnt;
    endfunction

    function automatic logic [KEEP_W-1:0] count_to_keep(input logic [3:0] cnt);
        logic [KEEP_W:0] m;
        m = (9'd1 << cnt) - 9'd1;
        return m[KEEP_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] keep_to_mask(input logic [KEEP_W-1:0] keep);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            m[i*BYTE_W +: BYTE_W] = {BYTE_W{keep[i]}};
        end
        return m;
    endfunction

    // Byte 0 ([7:0]) is processed first, LSB-first within each byte.
    function automatic logic [31:0] crc32_update(input logic [31:0]       crc_in,
                                                 input logic [DATA_W-1:0] data,
                                                 input int                n_bytes);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < KEEP_W; i++) begin
            if (i < n_bytes) begin
                c = c ^ {24'd0, data[i*BYTE_W +: BYTE_W]};
                for (int b = 0; b < BYTE_W; b++) begin
                    c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/CRC32_64bKEEP.sv
// -----------------------------------------------------------------------------
// CRC32_64bKEEP
// Ethernet CRC-32 over a 64-bit beat. The running remainder advances by all 8
// bytes on every enabled cycle; any cycle with i_en low re-initialises it to
// 0xFFFFFFFF, so a one-cycle hole between frames is enough to restart.
// o_crc_N is the finished FCS (inverted, reflected) assuming only the first N
// bytes of the current beat belong to the frame; registered on i_en.
// Ports:
//   i_clk, i_rst        clock, async active-high reset
//   i_en                beat enable
//   i_data..i_data_7    byte lanes 0..7 (lane 0 first on the wire)
//   o_crc_1..o_crc_8    FCS for a last beat of 1..8 valid bytes
// -----------------------------------------------------------------------------
module CRC32_64bKEEP
    import mac_tx_fcs_insert_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    input  logic [7:0]  i_data_1,
    input  logic [7:0]  i_data_2,
    input  logic [7:0]  i_data_3,
    input  logic [7:0]  i_data_4,
    input  logic [7:0]  i_data_5,
    input  logic [7:0]  i_data_6,
    input  logic [7:0]  i_data_7,
    output logic [31:0] o_crc_1,
    output logic [31:0] o_crc_2,
    output logic [31:0] o_crc_3,
    output logic [31:0] o_crc_4,
    output logic [31:0] o_crc_5,
    output logic [31:0] o_crc_6,
    output logic [31:0] o_crc_7,
    output logic [31:0] o_crc_8
);

    logic [DATA_W-1:0] beat;
    logic [31:0]       crc_p0;

    assign beat = {i_data_7, i_data_6, i_data_5, i_data_4,
                   i_data_3, i_data_2, i_data_1, i_data};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            crc_p0  <= CRC_INIT;
            o_crc_1 <= '0;
            o_crc_2 <= '0;
            o_crc_3 <= '0;
            o_crc_4 <= '0;
            o_crc_5 <= '0;
            o_crc_6 <= '0;
            o_crc_7 <= '0;
            o_crc_8 <= '0;
        end else if (i_en) begin
            crc_p0  <= crc32_update(crc_p0, beat, 8);
            o_crc_1 <= ~crc32_update(crc_p0, beat, 1);
            o_crc_2 <= ~crc32_update(crc_p0, beat, 2);
            o_crc_3 <= ~crc32_update(crc_p0, beat, 3);
            o_crc_4 <= ~crc32_update(crc_p0, beat, 4);
            o_crc_5 <= ~crc32_update(crc_p0, beat, 5);
            o_crc_6 <= ~crc32_update(crc_p0, beat, 6);
            o_crc_7 <= ~crc32_update(crc_p0, beat, 7);
            o_crc_8 <= ~crc32_update(crc_p0, beat, 8);
        end else begin
            crc_p0  <= CRC_INIT;
        end
    end

endmodule

// File: rtl/mac_tx_fcs_insert.sv
// -----------------------------------------------------------------------------
// mac_tx_fcs_insert
// 10G MAC TX stage: passes a 64-bit frame stream through with 1-cycle latency
// and appends the 4-byte FCS after the last data byte. If the FCS does not fit
// in the last beat it spills into one extra beat. A mid-frame valid drop aborts
// the frame (keep 0x00, last, user) and discards the rest of it.
// Parameters:
//   P_GAP_CYCLES  ready-low cycles after each accepted last beat (>=1)
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   s_axis_data/keep/last/valid  input frame stream, s_axis_ready back
//   m_axis_data/keep/last/user/valid  output stream with FCS (no back-pressure)
//   o_underrun                   1-cycle pulse on a mid-frame valid drop
// -----------------------------------------------------------------------------
module mac_tx_fcs_insert
    import mac_tx_fcs_insert_pkg::*;
#(
    parameter int P_GAP_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] s_axis_data,
    input  logic [KEEP_W-1:0] s_axis_keep,
    input  logic              s_axis_last,
    input  logic              s_axis_valid,
    output logic              s_axis_ready,
    output logic [DATA_W-1:0] m_axis_data,
    output logic [KEEP_W-1:0] m_axis_keep,
    output logic              m_axis_last,
    output logic              m_axis_user,
    output logic              m_axis_valid,
    output logic              o_underrun
);

    localparam int GAP_W = $clog2(P_GAP_CYCLES + 1);

    state_e             state_q, state_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               accept;
    logic               crc_en;
    logic [3:0]         in_cnt;

    logic [DATA_W-1:0]  data_p1;
    logic [3:0]         cnt_p1;
    logic               last_p1;
    logic               vld_p1;
    logic               abort_p1;
    logic               spill_p1;
    logic [31:0]        fcs_hold;
    logic [3:0]         cnt_sp;
    logic               need_spill;

    logic [31:0] crc_1, crc_2, crc_3, crc_4, crc_5, crc_6, crc_7, crc_8;
    logic [31:0] crc_sel;

    assign in_cnt = keep_to_count(s_axis_keep);
    assign accept = s_axis_valid & s_axis_ready;
    // Beats swallowed in DROP must not touch the CRC; the enable hole also re-inits it.
    assign crc_en = accept & (state_q != ST_DROP);

    CRC32_64bKEEP u_crc (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (crc_en),
        .i_data   (s_axis_data[7:0]),
        .i_data_1 (s_axis_data[15:8]),
        .i_data_2 (s_axis_data[23:16]),
        .i_data_3 (s_axis_data[31:24]),
        .i_data_4 (s_axis_data[39:32]),
        .i_data_5 (s_axis_data[47:40]),
        .i_data_6 (s_axis_data[55:48]),
        .i_data_7 (s_axis_data[63:56]),
        .o_crc_1  (crc_1),
        .o_crc_2  (crc_2),
        .o_crc_3  (crc_3),
        .o_crc_4  (crc_4),
        .o_crc_5  (crc_5),
        .o_crc_6  (crc_6),
        .o_crc_7  (crc_7),
        .o_crc_8  (crc_8)
    );

    always_comb begin
        crc_sel = crc_8;
        case (cnt_p1)
            4'd1:    crc_sel = crc_1;
            4'd2:    crc_sel = crc_2;
            4'd3:    crc_sel = crc_3;
            4'd4:    crc_sel = crc_4;
            4'd5:    crc_sel = crc_5;
            4'd6:    crc_sel = crc_6;
            4'd7:    crc_sel = crc_7;
            default: crc_sel = crc_8;
        endcase
    end

    // FSM: SPILL and GAP both hold ready low; SPILL marks that the last beat
    // overflowed, and is the first of the P_GAP_CYCLES ready-low cycles.
    always_comb begin
        state_nxt    = state_q;
        gap_nxt      = gap_cnt;
        s_axis_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_axis_ready = 1'b1;
                if (accept) begin
                    if (s_axis_last) begin
                        state_nxt = (in_cnt >= 4'd5) ? ST_SPILL : ST_GAP;
                        gap_nxt   = GAP_W'(P_GAP_CYCLES);
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                s_axis_ready = 1'b1;
                if (!s_axis_valid) begin
                    state_nxt = ST_DROP;
                end else if (s_axis_last) begin
                    state_nxt = (in_cnt >= 4'd5) ? ST_SPILL : ST_GAP;
                    gap_nxt   = GAP_W'(P_GAP_CYCLES);
                end
            end
            ST_DROP: begin
                s_axis_ready = 1'b1;
                if (accept && s_axis_last) begin
                    state_nxt = ST_GAP;
                    gap_nxt   = GAP_W'(P_GAP_CYCLES);
                end
            end
            ST_SPILL, ST_GAP: begin
                gap_nxt   = gap_cnt - GAP_W'(1);
                state_nxt = (gap_cnt <= GAP_W'(1)) ? ST_IDLE : ST_GAP;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            gap_cnt <= '0;
        end else begin
            state_q <= state_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    assign need_spill = vld_p1 & last_p1 & (cnt_p1 >= 4'd5);

    // ---- stage p1: accepted beat registered alongside the CRC result ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_p1    <= '0;
            cnt_p1     <= '0;
            last_p1    <= 1'b0;
            vld_p1     <= 1'b0;
            abort_p1   <= 1'b0;
            spill_p1   <= 1'b0;
            fcs_hold   <= '0;
            cnt_sp     <= '0;
            o_underrun <= 1'b0;
        end else begin
            vld_p1     <= crc_en;
            abort_p1   <= (state_q == ST_DATA) & ~s_axis_valid;
            o_underrun <= (state_q == ST_DATA) & ~s_axis_valid;
            spill_p1   <= need_spill;
            if (crc_en) begin
                data_p1 <= s_axis_data;
                cnt_p1  <= in_cnt;
                last_p1 <= s_axis_last;
            end
            if (need_spill) begin
                fcs_hold <= crc_sel;
                cnt_sp   <= cnt_p1;
            end
        end
    end

    // ---- output: FCS merged into the last beat, or the spill beat ----
    always_comb begin
        m_axis_valid = 1'b0;
        m_axis_data  = '0;
        m_axis_keep  = '0;
        m_axis_last  = 1'b0;
        m_axis_user  = 1'b0;
        if (abort_p1) begin
            m_axis_valid = 1'b1;
            m_axis_last  = 1'b1;
            m_axis_user  = 1'b1;
        end else if (spill_p1) begin
            // FCS bytes already sent = 8 - n; the rest start at lane 0.
            m_axis_valid = 1'b1;
            m_axis_data  = {32'd0, fcs_hold >> {(4'd8 - cnt_sp), 3'b000}};
            m_axis_keep  = count_to_keep(cnt_sp - 4'd4);
            m_axis_last  = 1'b1;
        end else if (vld_p1) begin
            m_axis_valid = 1'b1;
            if (last_p1) begin
                m_axis_data = (data_p1 & keep_to_mask(count_to_keep(cnt_p1)))
                            | ({32'd0, crc_sel} << {cnt_p1, 3'b000});
                if (cnt_p1 <= 4'd4) begin
                    m_axis_keep = count_to_keep(cnt_p1 + 4'd4);
                    m_axis_last = 1'b1;
                end else begin
                    m_axis_keep = '1;
                end
            end else begin
                m_axis_data = data_p1;
                m_axis_keep = '1;
            end
        end
    end

endmodule

// File: tb/tb_mac_tx_fcs_insert.sv
module tb_mac_tx_fcs_insert;

    localparam int P_GAP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_axis_data;
    logic [7:0]  s_axis_keep;
    logic        s_axis_last;
    logic        s_axis_valid;
    logic        s_axis_ready;
    logic [63:0] m_axis_data;
    logic [7:0]  m_axis_keep;
    logic        m_axis_last;
    logic        m_axis_user;
    logic        m_axis_valid;
    logic        o_underrun;

    int tests = 0;
    int fails = 0;
    int underruns = 0;

    logic [7:0]  frame_q[$];
    logic [73:0] out_q[$];
    logic [73:0] exp_q[$];

    always #5 clk = ~clk;

    mac_tx_fcs_insert #(.P_GAP_CYCLES(P_GAP)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .s_axis_data  (s_axis_data),
        .s_axis_keep  (s_axis_keep),
        .s_axis_last  (s_axis_last),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_keep  (m_axis_keep),
        .m_axis_last  (m_axis_last),
        .m_axis_user  (m_axis_user),
        .m_axis_valid (m_axis_valid),
        .o_underrun   (o_underrun)
    );

    // Output collector, sampled on the inactive edge.
    always @(negedge clk) begin
        if (m_axis_valid) out_q.push_back({m_axis_data, m_axis_keep, m_axis_last, m_axis_user});
        if (o_underrun) underruns++;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reference CRC-32 over frame_q (FCS value, byte 0 = [7:0]).
    function automatic logic [31:0] ref_crc();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (frame_q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frame_q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic set_frame(input int len, input int seed);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(8'((seed + i * 7) & 8'hFF));
    endtask

    task automatic beat_of(input int b, output logic [63:0] d, output logic [7:0] k, output logic l);
        int nb;
        nb = frame_q.size();
        d = '0;
        k = '0;
        for (int j = 0; j < 8; j++) begin
            if (b * 8 + j < nb) begin
                d[j*8 +: 8] = frame_q[b*8+j];
                k[j] = 1'b1;
            end
        end
        l = (b == (nb + 7) / 8 - 1);
    endtask

    task automatic build_exp();
        logic [7:0]  w[$];
        logic [31:0] c;
        logic [63:0] d;
        logic [7:0]  k;
        int          nb, nbeats;
        c = ref_crc();
        w = frame_q;
        for (int i = 0; i < 4; i++) w.push_back(c[i*8 +: 8]);
        nb = w.size();
        nbeats = (nb + 7) / 8;
        for (int b = 0; b < nbeats; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++) begin
                if (b * 8 + j < nb) begin
                    d[j*8 +: 8] = w[b*8+j];
                    k[j] = 1'b1;
                end
            end
            exp_q.push_back({d, k, (b == nbeats - 1), 1'b0});
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, output int waits);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        s_axis_keep  = k;
        s_axis_last  = l;
        waits = 0;
        while (!s_axis_ready && waits < 20) begin
            tick();
            waits++;
        end
        if (waits >= 20) check("ready_timeout", s_axis_ready, 1'b1);
        tick();
    endtask

    task automatic send_frame(output int first_wait);
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        int          w;
        first_wait = 0;
        build_exp();
        for (int b = 0; b < (frame_q.size() + 7) / 8; b++) begin
            beat_of(b, d, k, l);
            drive_beat(d, k, l, w);
            if (b == 0) first_wait = w;
        end
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        s_axis_keep  = '0;
        s_axis_last  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int budget;
        budget = 0;
        while (out_q.size() < n && budget < 60) begin
            tick();
            budget++;
        end
    endtask

    task automatic compare_outputs(input string tag);
        wait_out(exp_q.size());
        repeat (4) tick();
        check({tag, "_beats"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          w;
        logic [73:0] ob;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;

        rst          = 1'b1;
        s_axis_data  = '0;
        s_axis_keep  = '0;
        s_axis_last  = 1'b0;
        s_axis_valid = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_m_valid", m_axis_valid, 1'b0);
        check("rst_m_data",  m_axis_data,  64'd0);
        check("rst_m_keep",  m_axis_keep,  8'd0);
        check("rst_m_last",  m_axis_last,  1'b0);
        check("rst_m_user",  m_axis_user,  1'b0);
        check("rst_underrun", o_underrun,  1'b0);
        check("rst_ready",   s_axis_ready, 1'b1);
        rst = 1'b0;
        repeat (2) tick();

        // "123456789": known CRC 0xCBF43926
        frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send_frame(w);
        wait_out(2);
        check("c9_beat0", out_q[0], {64'h3837363534333231, 8'hFF, 1'b0, 1'b0});
        check("c9_beat1", out_q[1], {64'h000000CBF4392639, 8'h1F, 1'b1, 1'b0});
        compare_outputs("c9");

        // 64-byte frame: last beat full, FCS entirely in SPILL
        set_frame(64, 3);
        send_frame(w);
        wait_out(9);
        ob = out_q[7];
        check("f64_b7_keep_last", ob[9:1], {8'hFF, 1'b0});
        ob = out_q[8];
        check("f64_spill_keep_last", ob[9:1], {8'h0F, 1'b1});
        compare_outputs("f64");

        // n = 4: FCS fills lanes 4..7 of the last beat
        set_frame(12, 17);
        send_frame(w);
        wait_out(2);
        ob = out_q[1];
        check("n4_keep_last", ob[9:1], {8'hFF, 1'b1});
        compare_outputs("n4");

        // n = 5: 3 FCS bytes in last beat, 1 in SPILL
        set_frame(13, 40);
        send_frame(w);
        wait_out(3);
        ob = out_q[1];
        check("n5_keep_last", ob[9:1], {8'hFF, 1'b0});
        ob = out_q[2];
        check("n5_spill_keep_last", ob[9:1], {8'h01, 1'b1});
        compare_outputs("n5");

        // Back-to-back frames: ready low exactly P_GAP cycles after each last
        set_frame(20, 90);
        send_frame(w);
        set_frame(13, 11);
        send_frame(w);
        check("b2b_gap1", w, P_GAP);
        set_frame(7, 200);
        send_frame(w);
        check("b2b_gap2", w, P_GAP);
        compare_outputs("b2b");

        // Underrun: valid drops after two beats, remainder dropped
        check("underrun_before", underruns, 0);
        set_frame(24, 80);
        beat_of(0, d, k, l);
        drive_beat(d, k, l, w);
        exp_q.push_back({d, k, 1'b0, 1'b0});
        beat_of(1, d, k, l);
        drive_beat(d, k, l, w);
        exp_q.push_back({d, k, 1'b0, 1'b0});
        s_axis_valid = 1'b0;
        tick();
        exp_q.push_back({64'd0, 8'h00, 1'b1, 1'b1});
        beat_of(2, d, k, l);
        drive_beat(d, k, l, w);
        s_axis_valid = 1'b0;
        compare_outputs("underrun");
        check("underrun_pulses", underruns, 1);

        set_frame(30, 5);
        send_frame(w);
        compare_outputs("after_underrun");

        // Reset mid-frame: outputs clear asynchronously, no stray last
        set_frame(24, 160);
        beat_of(0, d, k, l);
        drive_beat(d, k, l, w);
        beat_of(1, d, k, l);
        drive_beat(d, k, l, w);
        beat_of(2, d, k, l);
        s_axis_data  = d;
        s_axis_keep  = k;
        s_axis_last  = 1'b0;
        s_axis_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_m_valid", m_axis_valid, 1'b0);
        check("arst_m_data",  m_axis_data,  64'd0);
        check("arst_m_keep",  m_axis_keep,  8'd0);
        check("arst_m_last",  m_axis_last,  1'b0);
        check("arst_ready",   s_axis_ready, 1'b1);
        s_axis_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_q.delete();
        exp_q.delete();
        repeat (5) tick();
        check("arst_no_stray", out_q.size(), 0);
        set_frame(15, 33);
        send_frame(w);
        compare_outputs("after_reset");
        check("underrun_total", underruns, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
